// File: rtl/adc_ctrl_pkg.sv
// Shared types and defaults for the ADC frame sequencer.
// No logic; state encoding and parameter consistency helpers only.
package adc_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_FILL   = 3'd2,
        ST_HOLD   = 3'd3,
        ST_DECODE = 3'd4,
        ST_FLUSH  = 3'd5
    } state_t;

    localparam int PERIOD_DEF        = 32;
    localparam int COUNTER_BIT_DEF   = 5;
    localparam int FRAME_CNT_BIT_DEF = 16;
    localparam int DROP_CNT_BIT_DEF  = 8;

    // The sample counter doubles as the buffer write pointer, so it must wrap exactly at PERIOD.
    function automatic bit period_matches(input int period, input int counter_bit);
        return period == (1 << counter_bit);
    endfunction

    localparam bit PERIOD_DEF_OK = period_matches(PERIOD_DEF, COUNTER_BIT_DEF);

endpackage

// File: rtl/adc_frame_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; one-cycle update latency.
// Increments are silently absorbed once the count reaches all-ones.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt
);

    always_ff @(posedge CLK) begin
        if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {WIDTH{1'b1}})) begin
            cnt <= cnt + WIDTH'(1);
        end
    end

endmodule

// File: rtl/adc_frame_ctrl.sv
// Frame sequencer for the ADC sample buffer: clear, fill PERIOD words, hand off, hold until decoded.
// START to FRAME_VALID is PERIOD+2 cycles minimum; ADC words arriving outside FILL are dropped and counted.
module adc_frame_ctrl
    import adc_ctrl_pkg::*;
#(
    parameter int PERIOD        = PERIOD_DEF,
    parameter int COUNTER_BIT   = COUNTER_BIT_DEF,
    parameter int FRAME_CNT_BIT = FRAME_CNT_BIT_DEF,
    parameter int DROP_CNT_BIT  = DROP_CNT_BIT_DEF
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     START,
    input  logic                     CONTINUOUS,
    input  logic                     ABORT,
    input  logic                     ADC_VALID,
    output logic                     ADC_READY,
    output logic                     BUF_CE,
    output logic                     BUF_RST,
    output logic                     FRAME_VALID,
    input  logic                     DEC_READY,
    input  logic                     DEC_DONE,
    output logic [COUNTER_BIT-1:0]   SAMPLE_CNT,
    output logic [FRAME_CNT_BIT-1:0] FRAME_CNT,
    output logic [DROP_CNT_BIT-1:0]  DROP_CNT,
    output logic                     BUSY
);

    if (!period_matches(PERIOD, COUNTER_BIT)) begin : g_bad_period
        $error("adc_frame_ctrl: PERIOD must equal 2**COUNTER_BIT");
    end

    state_t state, state_nxt;
    logic   accept;
    logic   last_word;
    logic   aborting;

    assign ADC_READY   = (state == ST_FILL);
    assign BUF_RST     = (state == ST_CLEAR) || (state == ST_FLUSH);
    assign FRAME_VALID = (state == ST_HOLD);
    assign BUSY        = (state != ST_IDLE);

    // Enable follows the word on the buffer input in the same cycle; ABORT suppresses the write.
    assign accept    = ADC_READY && ADC_VALID && !ABORT;
    assign BUF_CE    = BUF_RST || accept;
    assign last_word = (SAMPLE_CNT == COUNTER_BIT'(PERIOD - 1));
    assign aborting  = ABORT && (state != ST_IDLE) && (state != ST_FLUSH);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (aborting) begin
            state_nxt = ST_FLUSH;
        end else begin
            case (state)
                ST_IDLE:   if (START) state_nxt = ST_CLEAR;
                ST_CLEAR:  state_nxt = ST_FILL;
                ST_FILL:   if (accept && last_word) state_nxt = ST_HOLD;
                ST_HOLD:   if (DEC_READY) state_nxt = ST_DECODE;
                ST_DECODE: if (DEC_DONE) state_nxt = CONTINUOUS ? ST_FILL : ST_IDLE;
                ST_FLUSH:  state_nxt = ST_IDLE;
                default:   state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            SAMPLE_CNT <= '0;
        end else if (BUF_RST) begin
            SAMPLE_CNT <= '0;
        end else if (accept) begin
            SAMPLE_CNT <= last_word ? '0 : SAMPLE_CNT + COUNTER_BIT'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            FRAME_CNT <= '0;
        end else if (FRAME_VALID && DEC_READY && !ABORT) begin
            FRAME_CNT <= FRAME_CNT + FRAME_CNT_BIT'(1);
        end
    end

    sat_counter #(
        .WIDTH (DROP_CNT_BIT)
    ) u_drop_cnt (
        .CLK (CLK),
        .clr (RST),
        .inc (ADC_VALID && !accept),
        .cnt (DROP_CNT)
    );

endmodule

// File: tb/tb_adc_frame_ctrl.sv
// Self-checking bench for adc_frame_ctrl: per-cycle reference model plus directed literal checkpoints.
module tb_adc_frame_ctrl;

    localparam int P  = 32;
    localparam int CB = 5;
    localparam int FB = 16;
    localparam int DB = 8;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          START = 1'b0;
    logic          CONTINUOUS = 1'b0;
    logic          ABORT = 1'b0;
    logic          ADC_VALID = 1'b0;
    logic          DEC_READY = 1'b0;
    logic          DEC_DONE = 1'b0;
    logic          ADC_READY, BUF_CE, BUF_RST, FRAME_VALID, BUSY;
    logic [CB-1:0] SAMPLE_CNT;
    logic [FB-1:0] FRAME_CNT;
    logic [DB-1:0] DROP_CNT;

    adc_frame_ctrl #(
        .PERIOD        (P),
        .COUNTER_BIT   (CB),
        .FRAME_CNT_BIT (FB),
        .DROP_CNT_BIT  (DB)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .START       (START),
        .CONTINUOUS  (CONTINUOUS),
        .ABORT       (ABORT),
        .ADC_VALID   (ADC_VALID),
        .ADC_READY   (ADC_READY),
        .BUF_CE      (BUF_CE),
        .BUF_RST     (BUF_RST),
        .FRAME_VALID (FRAME_VALID),
        .DEC_READY   (DEC_READY),
        .DEC_DONE    (DEC_DONE),
        .SAMPLE_CNT  (SAMPLE_CNT),
        .FRAME_CNT   (FRAME_CNT),
        .DROP_CNT    (DROP_CNT),
        .BUSY        (BUSY)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: phase of the frame life cycle plus plain integer counts.
    localparam int M_IDLE = 0, M_CLEAR = 1, M_FILL = 2, M_HOLD = 3, M_DECODE = 4, M_FLUSH = 5;
    int m_phase  = M_IDLE;
    int m_words  = 0;
    int m_frames = 0;
    int m_drops  = 0;
    bit m_live   = 1'b0;
    bit m_took;

    always @(posedge CLK) begin
        if (RST) begin
            m_phase  = M_IDLE;
            m_words  = 0;
            m_frames = 0;
            m_drops  = 0;
            m_live   = 1'b1;
        end else if (m_live) begin
            m_took = (m_phase == M_FILL) && ADC_VALID && !ABORT;
            if (ADC_VALID && !m_took && m_drops < 255) m_drops++;
            if (ABORT && m_phase != M_IDLE && m_phase != M_FLUSH) begin
                m_phase = M_FLUSH;
            end else begin
                case (m_phase)
                    M_IDLE:   if (START) m_phase = M_CLEAR;
                    M_CLEAR:  begin m_words = 0; m_phase = M_FILL; end
                    M_FILL:   if (m_took) begin
                                  m_words++;
                                  if (m_words == P) begin m_words = 0; m_phase = M_HOLD; end
                              end
                    M_HOLD:   if (DEC_READY) begin m_frames = (m_frames + 1) % 65536; m_phase = M_DECODE; end
                    M_DECODE: if (DEC_DONE) m_phase = CONTINUOUS ? M_FILL : M_IDLE;
                    default:  begin m_words = 0; m_phase = M_IDLE; end
                endcase
            end
        end
    end

    always @(negedge CLK) begin
        if (m_live) begin
            check("adc_ready",   ADC_READY,   m_phase == M_FILL);
            check("buf_ce",      BUF_CE,      (m_phase == M_CLEAR) || (m_phase == M_FLUSH) ||
                                              ((m_phase == M_FILL) && ADC_VALID && !ABORT));
            check("buf_rst",     BUF_RST,     (m_phase == M_CLEAR) || (m_phase == M_FLUSH));
            check("frame_valid", FRAME_VALID, m_phase == M_HOLD);
            check("busy",        BUSY,        m_phase != M_IDLE);
            check("sample_cnt",  SAMPLE_CNT,  m_words);
            check("frame_cnt",   FRAME_CNT,   m_frames);
            check("drop_cnt",    DROP_CNT,    m_drops);
        end
    end

    task automatic next_cyc;
        @(posedge CLK);
        #2;
    endtask

    task automatic at_sample;
        @(negedge CLK);
        #1;
    endtask

    task automatic do_reset;
        RST = 1'b1; START = 1'b0; CONTINUOUS = 1'b0; ABORT = 1'b0;
        ADC_VALID = 1'b0; DEC_READY = 1'b0; DEC_DONE = 1'b0;
        next_cyc;
        next_cyc;
        RST = 1'b0;
        at_sample;
    endtask

    int fv_at;
    int ce_pulses;
    bit ok;

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, expected summary before 500us");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Back-to-back words: clear pulse, 32 writes, frame valid on cycle 34 after START.
        do_reset;
        check("rst_adc_ready", ADC_READY, 0);
        check("rst_buf_ce", BUF_CE, 0);
        check("rst_busy", BUSY, 0);
        check("rst_counts", {SAMPLE_CNT, FRAME_CNT, DROP_CNT}, 0);
        START = 1'b1;
        next_cyc;
        START = 1'b0;
        at_sample;
        check("clear_pulse", {BUF_CE, BUF_RST}, 2'b11);
        fv_at = 0; ce_pulses = 0;
        for (int c = 2; c <= 60; c++) begin
            next_cyc;
            ADC_VALID = 1'b1;
            at_sample;
            if (c == 33) check("sample_cnt_31", SAMPLE_CNT, 31);
            if (BUF_CE && !BUF_RST) ce_pulses++;
            if (FRAME_VALID) begin fv_at = c; break; end
        end
        check("fv_cycle", fv_at, 34);
        check("ce_pulses", ce_pulses, 32);
        check("sample_wrap", SAMPLE_CNT, 0);
        // Stall in HOLD with words arriving: all dropped, frame held.
        for (int k = 0; k < 10; k++) begin
            check("hold_no_ce", {BUF_CE, FRAME_VALID}, 2'b01);
            next_cyc;
            at_sample;
        end
        check("hold_drops", DROP_CNT, 10);
        ADC_VALID = 1'b0; DEC_READY = 1'b1; DEC_DONE = 1'b1;
        next_cyc;
        DEC_READY = 1'b0;
        at_sample;
        check("frame_cnt_1", FRAME_CNT, 1);
        check("done_ignored_in_handshake", BUSY, 1);
        next_cyc;
        DEC_DONE = 1'b0;
        at_sample;
        check("idle_after_done", BUSY, 0);

        // One word every third cycle: frame completes on cycle 96.
        do_reset;
        START = 1'b1;
        next_cyc;
        START = 1'b0;
        fv_at = 0;
        for (int c = 2; c <= 200; c++) begin
            next_cyc;
            ADC_VALID = ((c - 2) % 3 == 0);
            at_sample;
            if (c == 95) check("gap_sample_31", SAMPLE_CNT, 31);
            if (FRAME_VALID) begin fv_at = c; break; end
        end
        ADC_VALID = 1'b0;
        check("gap_fv_cycle", fv_at, 96);
        check("gap_drops", DROP_CNT, 0);

        // Abort with a word present at SAMPLE_CNT=17.
        do_reset;
        START = 1'b1;
        next_cyc;
        START = 1'b0;
        for (int c = 2; c <= 19; c++) begin
            next_cyc;
            ADC_VALID = 1'b1;
            ABORT = (c == 19);
            at_sample;
        end
        check("abort_at_17", SAMPLE_CNT, 17);
        check("abort_no_write", BUF_CE, 0);
        next_cyc;
        ADC_VALID = 1'b0; ABORT = 1'b0;
        at_sample;
        check("flush_pulse", {BUF_CE, BUF_RST, BUSY}, 3'b111);
        next_cyc;
        at_sample;
        check("abort_idle", BUSY, 0);
        check("abort_sample_cnt", SAMPLE_CNT, 0);
        check("abort_drops", DROP_CNT, 1);

        // Continuous mode, three frames with a 5-cycle decode each.
        do_reset;
        CONTINUOUS = 1'b1; ADC_VALID = 1'b1; START = 1'b1;
        next_cyc;
        START = 1'b0;
        for (int f = 0; f < 3; f++) begin
            ok = 1'b0;
            for (int n = 0; n < 100; n++) begin
                next_cyc;
                at_sample;
                if (FRAME_VALID) begin ok = 1'b1; break; end
            end
            check("cont_fv_seen", ok, 1);
            DEC_READY = 1'b1;
            next_cyc;
            DEC_READY = 1'b0;
            at_sample;
            for (int d = 2; d <= 5; d++) begin
                next_cyc;
                at_sample;
            end
            check("cont_decoding", {BUSY, ADC_READY}, 2'b10);
            next_cyc;
            DEC_DONE = 1'b1;
            next_cyc;
            DEC_DONE = 1'b0;
            at_sample;
            check("cont_refill", {ADC_READY, BUF_RST}, 2'b10);
        end
        check("cont_frames", FRAME_CNT, 3);
        // Reset in the middle of the refill.
        for (int k = 0; k < 5; k++) next_cyc;
        RST = 1'b1;
        next_cyc;
        RST = 1'b0;
        at_sample;
        check("midfill_rst_idle", BUSY, 0);
        check("midfill_rst_counts", {SAMPLE_CNT, FRAME_CNT, DROP_CNT}, 0);

        // Drop counter saturates.
        CONTINUOUS = 1'b0;
        for (int k = 0; k < 300; k++) next_cyc;
        at_sample;
        check("drop_saturate", DROP_CNT, 255);
        ADC_VALID = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
